// File: rtl/decoder16_pkg.sv
// rtl/decoder16_pkg.sv - shared types and widths for the switch-code LED decoder
package decoder16_pkg;

    localparam int LED_W  = 16;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SHOW = 2'b01,
        WALK = 2'b10
    } mode_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stability counter and rising-edge pulse for one button
module btn_debounce
    import decoder16_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/decoder16_led.sv
// rtl/decoder16_led.sv - registered 4-to-16 LED decoder with debounced load and walk buttons
module decoder16_led
    import decoder16_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 25_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              btn_load,
    input  logic              btn_walk,
    output logic [LED_W-1:0]  LED,
    output logic [1:0]        mode
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic              load_p, walk_p;
    logic [CODE_W-1:0] code_s1_q, code_s2_q;
    mode_t             state_q, state_d;
    logic [CODE_W-1:0] pos_q, pos_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [LED_W-1:0]  led_q, led_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_load),
        .level   (),
        .rise    (load_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_walk_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_walk),
        .level   (),
        .rise    (walk_p)
    );

    // Button actions take priority over a walk step; load beats walk.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        step_d  = '0;
        if (load_p) begin
            pos_d   = code_s2_q;
            state_d = SHOW;
        end else if (walk_p) begin
            state_d = (state_q == WALK) ? SHOW : WALK;
        end else if (state_q == WALK) begin
            if (step_q == STEP_W'(STEP_CYCLES - 1)) begin
                pos_d = pos_q + 1'b1;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
        led_d = (state_d == IDLE) ? '0 : (LED_W'(1) << pos_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_s1_q <= '0;
            code_s2_q <= '0;
            state_q   <= IDLE;
            pos_q     <= '0;
            step_q    <= '0;
            led_q     <= '0;
        end else begin
            code_s1_q <= code;
            code_s2_q <= code_s1_q;
            state_q   <= state_d;
            pos_q     <= pos_d;
            step_q    <= step_d;
            led_q     <= led_d;
        end
    end

    assign LED  = led_q;
    assign mode = state_q;

endmodule

// File: tb/tb_decoder16_led.sv
// tb/tb_decoder16_led.sv - directed vector bench for decoder16_led
`timescale 1ns/100ps
module tb_decoder16_led;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  code = 4'h0;
    logic        btn_load = 1'b0;
    logic        btn_walk = 1'b0;
    logic [15:0] LED;
    logic [1:0]  mode;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  code;
        logic        load;
        logic        walk;
        int          cycles;
        logic [15:0] led;
        logic [1:0]  mode;
    } vec_t;

    vec_t vecs[10];

    decoder16_led #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .code     (code),
        .btn_load (btn_load),
        .btn_walk (btn_walk),
        .LED      (LED),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] exp_led, input logic [1:0] exp_mode);
        n_checks++;
        if (LED === exp_led && mode === exp_mode) begin
            n_pass++;
        end else begin
            $display("FAIL %s: LED=%h mode=%b, expected LED=%h mode=%b", name, LED, mode, exp_led, exp_mode);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        btn_load = 1'b0;
        btn_walk = 1'b0;
        code     = 4'h0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic press_load(input logic [3:0] c);
        code     = c;
        btn_load = 1'b1;
        repeat (8) tick();
        btn_load = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        logic [15:0] el;
        logic [1:0]  em;

        vecs[0] = '{4'h0, 1'b1, 1'b0, 8, 16'h0001, 2'b01};
        vecs[1] = '{4'h0, 1'b0, 1'b0, 8, 16'h0001, 2'b01};
        vecs[2] = '{4'hF, 1'b1, 1'b0, 8, 16'h8000, 2'b01};
        vecs[3] = '{4'hF, 1'b0, 1'b0, 8, 16'h8000, 2'b01};
        vecs[4] = '{4'h7, 1'b1, 1'b0, 8, 16'h0080, 2'b01};
        vecs[5] = '{4'h7, 1'b0, 1'b0, 8, 16'h0080, 2'b01};
        vecs[6] = '{4'h3, 1'b0, 1'b1, 8, 16'h0080, 2'b10};
        vecs[7] = '{4'h3, 1'b0, 1'b0, 8, 16'h0400, 2'b10};
        vecs[8] = '{4'h2, 1'b1, 1'b0, 8, 16'h0004, 2'b01};
        vecs[9] = '{4'h2, 1'b0, 1'b0, 8, 16'h0004, 2'b01};

        // Reset state
        do_reset();
        check("reset", 16'h0000, 2'b00);

        // Load latency: first change at edge 7
        code     = 4'hA;
        btn_load = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e < 7) check($sformatf("load_lat_e%0d", e), 16'h0000, 2'b00);
            else       check($sformatf("load_lat_e%0d", e), 16'h0400, 2'b01);
        end
        btn_load = 1'b0;
        repeat (10) tick();
        check("load_release", 16'h0400, 2'b01);

        // Short glitch is rejected
        do_reset();
        code     = 4'h5;
        btn_load = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == 3) btn_load = 1'b0;
            if (e % 3 == 0) check($sformatf("glitch_e%0d", e), 16'h0000, 2'b00);
        end

        // Table-driven sequence
        do_reset();
        for (int i = 0; i < 10; i++) begin
            code     = vecs[i].code;
            btn_load = vecs[i].load;
            btn_walk = vecs[i].walk;
            repeat (vecs[i].cycles) tick();
            check($sformatf("vec%0d", i), vecs[i].led, vecs[i].mode);
        end

        // Walk with wrap, then freeze
        do_reset();
        press_load(4'hE);
        check("walk_pre", 16'h4000, 2'b01);
        btn_walk = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (e < 7)       begin el = 16'h4000; em = 2'b01; end
            else if (e < 10) begin el = 16'h4000; em = 2'b10; end
            else if (e < 13) begin el = 16'h8000; em = 2'b10; end
            else if (e < 16) begin el = 16'h0001; em = 2'b10; end
            else if (e < 19) begin el = 16'h0002; em = 2'b10; end
            else if (e < 20) begin el = 16'h0004; em = 2'b10; end
            else             begin el = 16'h0004; em = 2'b01; end
            check($sformatf("walk_e%0d", e), el, em);
            if (e == 8)  btn_walk = 1'b0;
            if (e == 13) btn_walk = 1'b1;
        end
        btn_walk = 1'b0;

        // Simultaneous presses: load wins
        do_reset();
        code     = 4'h3;
        btn_load = 1'b1;
        btn_walk = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e < 7) check($sformatf("both_e%0d", e), 16'h0000, 2'b00);
            else       check($sformatf("both_e%0d", e), 16'h0008, 2'b01);
            if (e == 8) begin
                btn_load = 1'b0;
                btn_walk = 1'b0;
            end
        end

        // Asynchronous reset mid-walk
        do_reset();
        press_load(4'h5);
        btn_walk = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 7) check("rstwalk_enter", 16'h0020, 2'b10);
        end
        check("rstwalk_before", 16'h0020, 2'b10);
        btn_walk = 1'b0;
        rst_n    = 1'b0;
        #0.5;
        check("rstwalk_async", 16'h0000, 2'b00);
        #0.5;
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e % 5 == 0) check($sformatf("rstwalk_idle_e%0d", e), 16'h0000, 2'b00);
        end
        press_load(4'h7);
        check("rstwalk_reload", 16'h0080, 2'b01);

        // Code change without press is ignored
        do_reset();
        press_load(4'h1);
        check("hold_load", 16'h0002, 2'b01);
        code = 4'h9;
        repeat (10) tick();
        check("hold_after", 16'h0002, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decoder16_led.md
# decoder16_led

Registered 4-to-16 decoder that drives the 16 board LEDs from a 4-bit code on the switches. It is the return path of the 16-switch-to-4-LED encoder. A debounced `load` button latches the code and shows it as a one-hot LED pattern. A debounced `walk` button toggles an auto-stepping mode in which the lit LED rotates. It sits between the board switches/buttons and the LED pins on the BASYS 3 top level.

## Interface
Reset is asynchronous and active-low; the block has one clock.

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000 — consecutive stable cycles needed before a button level is accepted (10 ms at 100 MHz).
- `STEP_CYCLES`, default 25_000_000 — cycles per walk step (0.25 s at 100 MHz).

Ports:
- `clk` input 1 — 100 MHz board clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `code` input 4 — code from `sw[3:0]`, asynchronous to `clk`.
- `btn_load` input 1 — raw load button, active high, bouncy.
- `btn_walk` input 1 — raw walk button, active high, bouncy.
- `LED` output 16 — registered one-hot pattern, or all zero.
- `mode` output 2 — current state: 00 IDLE, 01 SHOW, 10 WALK.

## Operation
- `code`, `btn_load` and `btn_walk` each pass through a 2-flop synchronizer.
- Debounce, per button:
  - The counter increments while the synchronized level differs from the accepted level.
  - The counter clears to 0 whenever the two levels are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with the levels still differing, the accepted level flips and the counter clears.
  - A rising edge of the accepted level produces a one-cycle pulse, `load_p` or `walk_p`.
- State machine, with registers `pos[3:0]` and `state`:
  - IDLE: `LED`=0. On `load_p`: `pos`←synchronized code, go to SHOW. On `walk_p`: go to WALK with `pos` unchanged (0 after reset).
  - SHOW: `LED`=1<<`pos`. On `load_p`: relatch `pos` and stay in SHOW. On `walk_p`: go to WALK.
  - WALK: `LED`=1<<`pos`. The step counter clears on entry. `pos` increments every `STEP_CYCLES` cycles and wraps 15→0.
    - On `walk_p`: go to SHOW, freezing the current `pos`.
    - On `load_p`: relatch `pos` and go to SHOW.
- Simultaneous `load_p` and `walk_p` in one cycle: load wins. `pos`←code, state SHOW.
- A step boundary coinciding with `load_p` or `walk_p`: the button action wins and the step increment is discarded.
- `LED` and `mode` are registered and decoded from next-state values, so they change on the same edge as `state`/`pos`.
- Reset values: `LED`=16'h0000, `mode`=2'b00, `pos`=0, all counters 0, accepted button levels 0, synchronizers 0.
- Reset mid-operation, including mid-debounce and mid-walk: all outputs clear immediately (asynchronously). After release the block stays in IDLE until a button pulse.

## Timing
- Let edge 1 be the first clock edge that samples a raw button high, with the raw input held high afterwards.
  - The synchronizer output is high after edge 2.
  - The accepted level is high after edge 2+`DEBOUNCE_CYCLES`.
  - `LED`/`mode` update at edge 3+`DEBOUNCE_CYCLES`.
- A raw pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no pulse and no output change.
- The code latched is the synchronized `code` at the `load_p` cycle. The code must be stable 2 cycles earlier.
- Walk step: `LED` advances exactly every `STEP_CYCLES` edges. The first advance occurs `STEP_CYCLES` edges after the edge that entered WALK.
- Button release is debounced the same way. Release produces no pulse.

## Structure
- Package `decoder16_pkg` holds:
  - the `mode_t` enum: IDLE=2'b00, SHOW=2'b01, WALK=2'b10;
  - `LED_W`=16 and `CODE_W`=4 constants.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `btn_raw`, `level`, `rise`) contains the synchronizer, counter and edge detect. It is instantiated twice.
- The code synchronizer, state machine, step counter and output register live in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `STEP_CYCLES`=3.
- Reset, then `code`=4'hA and `btn_load` held high 10 cycles → `LED`=16'h0400 and `mode`=01 first at edge 7; no change earlier.
- Glitch: `btn_load` high 3 cycles then low, with `code`=4'h5 → `LED` stays 16'h0000, `mode` stays 00.
- Load `code`=4'hE, then press `walk` → `LED`=16'h4000, then 16'h8000 three edges later, then 16'h0001 (wrap) three edges after that. Pressing `walk` again freezes the current value with `mode`=01.
- `btn_load` and `btn_walk` raised on the same cycle with `code`=4'h3 → at edge 7 `LED`=16'h0008, `mode`=01; WALK is never entered.
- `rst_n` low for 1 ns mid-walk with `LED`=16'h0020 → `LED`=0 and `mode`=00 immediately. They stay there after release until a new debounced press.
- Load `code`=4'h1, then change `code` to 4'h9 without pressing → `LED` holds 16'h0002.
